// File: rtl/bsg_cache_pkg.sv
// rtl/bsg_cache_pkg.sv - shared cache types: store-buffer drain FSM state encoding.
package bsg_cache_pkg;

    typedef enum logic [1:0] {
        e_sbuf_idle  = 2'd0,
        e_sbuf_flush = 2'd1,
        e_sbuf_done  = 2'd2
    } sbuf_drain_state_e;

endpackage

// File: rtl/bsg_dff_en.sv
// rtl/bsg_dff_en.sv - enabled data register with no reset.
module bsg_dff_en #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_r;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            data_r <= data_i;
        end
    end

    assign data_o = data_r;

endmodule

// File: rtl/bsg_cache_sbuf_drain.sv
// rtl/bsg_cache_sbuf_drain.sv - drains the store-buffer queue into data memory through
// one holding register; an observing FSM reports flush completion.
module bsg_cache_sbuf_drain
    import bsg_cache_pkg::*;
#(
    parameter int width_p       = 32,
    parameter int count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [width_p-1:0]       data_i,
    output logic                     yumi_o,
    input  logic                     empty_i,
    input  logic                     stall_i,
    output logic                     mem_v_o,
    output logic [width_p-1:0]       mem_data_o,
    input  logic                     mem_ready_i,
    input  logic                     flush_i,
    output logic                     flush_done_o,
    output logic                     busy_o,
    output logic [count_width_p-1:0] drained_count_o
);

    logic                     hold_v_r;
    logic [width_p-1:0]       hold_data_r;
    logic                     accept;
    logic [count_width_p-1:0] count_r;
    sbuf_drain_state_e        state_r, state_n;

    assign mem_v_o    = hold_v_r & ~stall_i;
    assign mem_data_o = hold_data_r;
    assign accept     = mem_v_o & mem_ready_i;
    // Gated by reset so the queue is never acknowledged while the holder is being cleared.
    assign yumi_o     = v_i & (~hold_v_r | accept) & ~reset_i;

    bsg_dff_en #(.width_p(width_p)) hold_reg (
        .clk_i  (clk_i),
        .en_i   (yumi_o),
        .data_i (data_i),
        .data_o (hold_data_r)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hold_v_r <= 1'b0;
        end else if (yumi_o) begin
            hold_v_r <= 1'b1;
        end else if (accept) begin
            hold_v_r <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (accept) begin
            count_r <= count_r + 1'b1;
        end
    end

    assign drained_count_o = count_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_sbuf_idle;
        end else begin
            state_r <= state_n;
        end
    end

    // Once in FLUSH the FSM ignores flush_i, so a started flush always completes.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_sbuf_idle:  if (flush_i) state_n = e_sbuf_flush;
            e_sbuf_flush: if (empty_i & ~v_i & ~hold_v_r) state_n = e_sbuf_done;
            e_sbuf_done:  state_n = e_sbuf_idle;
            default:      state_n = e_sbuf_idle;
        endcase
    end

    assign flush_done_o = (state_r == e_sbuf_done);
    assign busy_o       = hold_v_r | (state_r != e_sbuf_idle);

endmodule

// File: tb/tb_bsg_cache_sbuf_drain.sv
// tb/tb_bsg_cache_sbuf_drain.sv - scoreboard bench for bsg_cache_sbuf_drain.
module tb_bsg_cache_sbuf_drain;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [31:0] data_i;
    logic        yumi_o;
    logic        empty_i;
    logic        stall_i;
    logic        mem_v_o;
    logic [31:0] mem_data_o;
    logic        mem_ready_i;
    logic        flush_i;
    logic        flush_done_o;
    logic        busy_o;
    logic [15:0] drained_count_o;

    bsg_cache_sbuf_drain #(.width_p(32), .count_width_p(16)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .v_i             (v_i),
        .data_i          (data_i),
        .yumi_o          (yumi_o),
        .empty_i         (empty_i),
        .stall_i         (stall_i),
        .mem_v_o         (mem_v_o),
        .mem_data_o      (mem_data_o),
        .mem_ready_i     (mem_ready_i),
        .flush_i         (flush_i),
        .flush_done_o    (flush_done_o),
        .busy_o          (busy_o),
        .drained_count_o (drained_count_o)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    logic [31:0] src_q[$];
    logic [31:0] exp_q[$];
    int unsigned model_count = 0;
    logic stall_k = 0, ready_k = 1, flush_k = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Source queue model feeds the DUT; every entry is expected at memory in order.
    task automatic push(input logic [31:0] d);
        src_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        v_i         = (src_q.size() != 0);
        data_i      = v_i ? src_q[0] : $urandom;
        empty_i     = ~v_i;
        stall_i     = stall_k;
        mem_ready_i = ready_k;
        flush_i     = flush_k;
        @(negedge clk);
        if (yumi_o && src_q.size() != 0) void'(src_q.pop_front());
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_mem_v", mem_v_o, 0);
        check("rst_count", drained_count_o, 0);
        src_q.delete();
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_done", flush_done_o, 0);
            check("rst_busy", busy_o, 0);
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset_i) begin
            model_count = 0;
        end else begin
            check("yumi_needs_v", yumi_o & ~v_i, 0);
            check("mem_v_during_stall", mem_v_o & stall_i, 0);
            check("drained_count", drained_count_o, 16'(model_count));
            if (mem_v_o && mem_ready_i) begin
                if (exp_q.size() == 0) check("unexpected_write", 1, 0);
                else check("write_data", mem_data_o, exp_q.pop_front());
                model_count++;
            end
        end
    end

    initial begin
        int last_acc, done_at, done_cnt, s;
        bit seen;
        reset_i = 1'b1; v_i = 1'b1; data_i = 32'hDEAD_BEEF; empty_i = 1'b0;
        stall_i = 1'b0; mem_ready_i = 1'b1; flush_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_yumi", yumi_o, 0);
        check("reset_mem_v", mem_v_o, 0);
        check("reset_done", flush_done_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_count", drained_count_o, 0);
        @(posedge clk);
        #1;
        reset_i = 1'b0; flush_i = 1'b0; v_i = 1'b0; empty_i = 1'b1;

        // single write latency
        push(32'hA5A5_0001);
        step();
        check("t1_yumi", yumi_o, 1);
        check("t1_mem_v_early", mem_v_o, 0);
        step();
        check("t1_mem_v", mem_v_o, 1);
        check("t1_data", mem_data_o, 32'hA5A5_0001);
        step();
        check("t1_count", drained_count_o, 1);

        // back-to-back
        push(32'h11); push(32'h22); push(32'h33);
        step(); check("b2b_yumi0", yumi_o, 1);
        step(); check("b2b_yumi1", yumi_o, 1); check("b2b_d0", mem_data_o, 32'h11); check("b2b_v0", mem_v_o, 1);
        step(); check("b2b_yumi2", yumi_o, 1); check("b2b_d1", mem_data_o, 32'h22); check("b2b_v1", mem_v_o, 1);
        step(); check("b2b_yumi3", yumi_o, 0); check("b2b_d2", mem_data_o, 32'h33); check("b2b_v2", mem_v_o, 1);
        step();

        // stall holds entry
        push(32'h44);
        step(); check("stall_load", yumi_o, 1);
        stall_k = 1; push(32'h55);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_mem_v", mem_v_o, 0);
            check("stall_yumi", yumi_o, 0);
        end
        stall_k = 0;
        step(); check("unstall_d0", mem_data_o, 32'h44); check("unstall_yumi", yumi_o, 1);
        step(); check("unstall_d1", mem_data_o, 32'h55); check("unstall_v1", mem_v_o, 1);
        step(); step();

        // flush with two entries
        push(32'h0F0F_0001); push(32'h0F0F_0002);
        flush_k = 1;
        last_acc = -1; done_at = -1; done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            flush_k = 0;
            if (mem_v_o && mem_ready_i) last_acc = i;
            if (flush_done_o) begin done_cnt++; done_at = i; end
        end
        check("flush_done_count", done_cnt, 1);
        check("flush_done_timing", done_at, last_acc + 2);
        check("flush_busy_after", busy_o, 0);

        // flush while already empty
        flush_k = 1;
        step(); check("eflush_c0", flush_done_o, 0);
        flush_k = 0;
        step(); check("eflush_c1", flush_done_o, 0);
        step(); check("eflush_c2", flush_done_o, 1);
        step(); check("eflush_c3", flush_done_o, 0);

        // async reset mid-flush with an entry held
        ready_k = 0; flush_k = 1;
        push(32'h7777_0001);
        step(); flush_k = 0;
        step(); check("midrst_held", mem_v_o, 1); check("midrst_busy", busy_o, 1);
        apply_reset();
        ready_k = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_done", flush_done_o, 0);
        end
        check("midrst_count", drained_count_o, 0);

        // randomized bursts, each ending in a flush
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 2) == 0) push($urandom);
                stall_k = ($urandom_range(0, 3) == 0);
                ready_k = ($urandom_range(0, 3) != 0);
                step();
            end
            flush_k = 1;
            seen = 0;
            s = 0;
            while (!seen && s < 400) begin
                stall_k = ($urandom_range(0, 3) == 0);
                ready_k = ($urandom_range(0, 3) != 0);
                step();
                flush_k = 0;
                if (flush_done_o) begin
                    seen = 1;
                    check("rflush_src_empty", src_q.size(), 0);
                    check("rflush_exp_empty", exp_q.size(), 0);
                end
                s++;
            end
            check("rflush_completed", seen, 1);
            step();
            check("rflush_single_pulse", flush_done_o, 0);
            check("rflush_idle", busy_o, 0);
        end

        // counter wrap
        apply_reset();
        stall_k = 0; ready_k = 1; flush_k = 0;
        for (int i = 0; i < 65535; i++) begin
            push(i);
            step();
        end
        repeat (3) step();
        check("wrap_pre", drained_count_o, 16'hFFFF);
        push(32'hCAFE_0000);
        repeat (3) step();
        check("wrap_post", drained_count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
